stream_downsize: RTL and testbench

STREAM_DOWNSIZE -- requirements
Module: stream_downsize

---
 rtl/stream_pkg.sv | 21 ++
 rtl/stream_downsize.sv | 141 ++++++++++++++
 tb/tb_stream_downsize.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// ---------------------------------------------------------------------------
// stream_pkg -- types and helpers shared by the stream blocks.
//   state_e     : downsizer control state (IDLE = holding register empty,
//                 SEND = word held and beats being offered)
//   beat_cw()   : width of a beat-count/beat-index field, max(1, clog2(ratio))
// ---------------------------------------------------------------------------
package stream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // A 1-beat word still needs a 1-bit field so ports never collapse to zero width.
    function automatic int unsigned beat_cw(input int ratio);
        int unsigned w;
        w = (ratio > 1) ? int'($clog2(ratio)) : 1;
        return w;
    endfunction

endpackage : stream_pkg

// File: rtl/stream_downsize.sv
// ---------------------------------------------------------------------------
// stream_downsize -- splits one wide input word into up to RATIO narrow
// output beats. Sits directly downstream of the generic fifo block.
//
// Parameters
//   OUT_WIDTH : bits per output beat (>= 1)
//   RATIO     : output beats per input word (>= 1)
//
// Ports
//   clk      in   sole clock, rising edge
//   rst      in   synchronous active-high reset
//   w_valid  in   input word offered
//   w_ready  out  input word accepted when w_valid && w_ready
//   w_data   in   input word, beat k at [k*OUT_WIDTH +: OUT_WIDTH]
//   w_beats  in   valid beats minus one (saturated to RATIO-1)
//   w_last   in   word ends a packet
//   r_valid  out  output beat offered
//   r_ready  in   output beat consumed when r_valid && r_ready
//   r_data   out  current beat
//   r_last   out  final valid beat of a word that had w_last set
//
// Build option
//   STREAM_DOWNSIZE_MSB_FIRST_EN : when defined, beats leave most-significant
//   first (beat RATIO-1 first, counting down). Default is beat 0 first.
// ---------------------------------------------------------------------------
module stream_downsize
    import stream_pkg::*;
#(
    parameter int OUT_WIDTH = 8,
    parameter int RATIO     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          w_valid,
    output logic                          w_ready,
    input  logic [OUT_WIDTH*RATIO-1:0]    w_data,
    input  logic [beat_cw(RATIO)-1:0]     w_beats,
    input  logic                          w_last,
    output logic                          r_valid,
    input  logic                          r_ready,
    output logic [OUT_WIDTH-1:0]          r_data,
    output logic                          r_last
);

    localparam int unsigned CW   = beat_cw(RATIO);
    localparam int unsigned IN_W = OUT_WIDTH * RATIO;
    localparam logic [CW-1:0] MAX_IDX = CW'(RATIO - 1);

    // Reject impossible geometries at elaboration time.
    if (OUT_WIDTH < 1 || RATIO < 1) begin : g_bad_param
        $fatal(1, "stream_downsize: OUT_WIDTH and RATIO must both be >= 1");
    end

    state_e                r_state;
    logic [CW-1:0]         r_idx;
    logic [CW-1:0]         r_lim;
    logic                  r_wlast;
    logic [IN_W-1:0]       r_word;

    logic [CW-1:0]         w_beats_sat;
    logic [CW-1:0]         w_first_idx;
    logic [CW-1:0]         w_lim_in;
    logic [CW-1:0]         w_next_idx;
    logic                  w_final;
    logic                  w_load;
    logic [OUT_WIDTH-1:0]  w_beat_arr [RATIO];

    // Out-of-range beat counts behave as a full word.
    assign w_beats_sat = (w_beats > MAX_IDX) ? MAX_IDX : w_beats;

    // Beat order: start index, final index and step direction.
`ifdef STREAM_DOWNSIZE_MSB_FIRST_EN
    assign w_first_idx = MAX_IDX;
    assign w_lim_in    = CW'(MAX_IDX - w_beats_sat);
    assign w_next_idx  = CW'(r_idx - CW'(1));
`else
    assign w_first_idx = '0;
    assign w_lim_in    = w_beats_sat;
    assign w_next_idx  = CW'(r_idx + CW'(1));
`endif

    // Slice the held word into addressable beats.
    for (genvar k = 0; k < RATIO; k++) begin : g_beat
        assign w_beat_arr[k] = r_word[k*OUT_WIDTH +: OUT_WIDTH];
    end

    assign w_final = (r_idx == r_lim);
    assign r_valid = (r_state == SEND);
    // A new word may enter in the very cycle the final beat leaves.
    assign w_ready = (r_state == IDLE) || (w_final && r_ready);
    assign w_load  = w_valid && w_ready;
    assign r_data  = w_beat_arr[r_idx];
    assign r_last  = r_valid && r_wlast && w_final;

    // Holding register data; contents are irrelevant while IDLE, so no reset.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_word <= w_data;
        end
    end

    // Control state machine: load, step through beats, reload or go idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_lim   <= '0;
            r_wlast <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_state <= SEND;
                        r_idx   <= w_first_idx;
                        r_lim   <= w_lim_in;
                        r_wlast <= w_last;
                    end
                end
                SEND: begin
                    if (r_ready) begin
                        if (w_final) begin
                            if (w_valid) begin
                                r_idx   <= w_first_idx;
                                r_lim   <= w_lim_in;
                                r_wlast <= w_last;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_idx <= w_next_idx;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : stream_downsize

// File: tb/tb_stream_downsize.sv
// ---------------------------------------------------------------------------
// tb_stream_downsize -- scoreboard bench for stream_downsize (8-bit beats,
// ratio 4). Accepted words are expanded into expected beats by a queue model;
// a negedge monitor compares every output cycle against the queue head.
// ---------------------------------------------------------------------------
module tb_stream_downsize;

    localparam int BW = 8;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          w_valid;
    logic          w_ready;
    logic [31:0]   w_data;
    logic [1:0]    w_beats;
    logic          w_last;
    logic          r_valid;
    logic          r_ready;
    logic [7:0]    r_data;
    logic          r_last;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       fin;
    } beat_t;

    beat_t q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    bit    mon_en      = 1'b0;
    bit    rr_random   = 1'b0;

    stream_downsize #(.OUT_WIDTH(BW), .RATIO(NB)) dut (
        .clk     (clk),
        .rst     (rst),
        .w_valid (w_valid),
        .w_ready (w_ready),
        .w_data  (w_data),
        .w_beats (w_beats),
        .w_last  (w_last),
        .r_valid (r_valid),
        .r_ready (r_ready),
        .r_data  (r_data),
        .r_last  (r_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a word with b+1 valid beats yields those beats in stream order.
    task automatic push_model(input logic [31:0] d, input logic [1:0] b, input logic l);
        beat_t e;
        int    pos;
        for (int k = 0; k <= int'(b); k++) begin
`ifdef STREAM_DOWNSIZE_MSB_FIRST_EN
            pos = NB - 1 - k;
`else
            pos = k;
`endif
            e.data = d[pos*BW +: BW];
            e.fin  = (k == int'(b));
            e.last = l && e.fin;
            q.push_back(e);
        end
    endtask

    // Offer a word until accepted; leaves w_valid high for back-to-back use.
    task automatic send_word(input logic [31:0] d, input logic [1:0] b, input logic l);
        int n = 0;
        bit acc = 1'b0;
        w_valid = 1'b1;
        w_data  = d;
        w_beats = b;
        w_last  = l;
        while (!acc) begin
            @(negedge clk);
            acc = w_ready;
            if (!acc) begin
                n++;
                if (n > 300) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL accept_timeout: got w_ready 0 expected 1 at %0t", $time);
                    w_valid = 1'b0;
                    return;
                end
            end
        end
        @(posedge clk);
        #1;
        push_model(d, b, l);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mon_en  = 1'b0;
        w_valid = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_r_valid", 32'(r_valid), 32'd0);
        chk("rst_w_ready", 32'(w_ready), 32'd1);
        chk("rst_r_last",  32'(r_last),  32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: presence, w_ready and beat content checked every cycle.
    always @(negedge clk) begin
        logic exp_v;
        logic exp_wr;
        if (mon_en && !rst) begin
            exp_v  = (q.size() != 0);
            exp_wr = 1'b1;
            if (exp_v) exp_wr = q[0].fin && r_ready;
            chk("r_valid", 32'(r_valid), 32'(exp_v));
            chk("w_ready", 32'(w_ready), 32'(exp_wr));
            if (r_valid && exp_v) begin
                chk("r_data", 32'(r_data), 32'(q[0].data));
                chk("r_last", 32'(r_last), 32'(q[0].last));
                if (r_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rr_random) r_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        rst     = 1'b1;
        w_valid = 1'b0;
        w_data  = '0;
        w_beats = '0;
        w_last  = 1'b0;
        r_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("init_r_valid", 32'(r_valid), 32'd0);
        chk("init_w_ready", 32'(w_ready), 32'd1);
        chk("init_r_last",  32'(r_last),  32'd0);
        @(posedge clk);
        #1;

        // Single full word, consumer always ready.
        r_ready = 1'b1;
        send_word(32'h44332211, 2'd3, 1'b1);
        w_valid = 1'b0;
        drain();

        // Back-to-back words must stream without a bubble.
        send_word(32'hA3A2A1A0, 2'd3, 1'b0);
        send_word(32'hB3B2B1B0, 2'd3, 1'b1);
        w_valid = 1'b0;
        drain();

        // Short word of two beats, then idle.
        send_word(32'hDDCCBBAA, 2'd1, 1'b1);
        w_valid = 1'b0;
        drain();

        // Consumer stalls for three cycles on the second beat.
        send_word(32'h44332211, 2'd3, 1'b1);
        w_valid = 1'b0;
        @(posedge clk);
        #1;
        r_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        r_ready = 1'b1;
        drain();

        // Reset after the first beat discards the rest of the word.
        send_word(32'h44332211, 2'd3, 1'b1);
        w_valid = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        send_word(32'h88776655, 2'd3, 1'b1);
        w_valid = 1'b0;
        drain();

        // Randomized traffic with random backpressure and input gaps.
        rr_random = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                w_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send_word($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        w_valid   = 1'b0;
        rr_random = 1'b0;
        r_ready   = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_stream_downsize
